alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/select interface; replaces the free-running stimulus driver.
- Accepts one command at a time on a valid/ready command port and drives A/B/ALU_Sel into the registered ALU.
- Waits the operation-dependent ALU latency, captures ALU_Out/CarryOut and returns them, with the command tag, on a valid/ready response port.
- Traps divide-by-zero without issuing it to the ALU; counts completed operations.

Parameters:
- DATA_W, 8, operand/result width
- DEF_LAT, 1, extra wait cycles after issue for all ops except multiply
- MUL_LAT, 2, extra wait cycles after issue for multiply (sel 2)
- CNT_W, 16, width of op_count

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_sel  in  4  ALU opcode 0..15
- cmd_tag  in  4  opaque tag returned with the response
- alu_a  out  DATA_W  to ALU A
- alu_b  out  DATA_W  to ALU B
- alu_sel  out  4  to ALU ALU_Sel
- alu_out  in  DATA_W  from ALU ALU_Out
- alu_carry  in  1  from ALU CarryOut
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DATA_W  captured result
- rsp_carry  out  1  captured carry, add only
- rsp_err  out  1  divide-by-zero trap
- rsp_tag  out  4  tag of the command
- busy  out  1  state != IDLE
- op_count  out  CNT_W  number of completed response handshakes

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1; the FSM enters IDLE. Reset mid-operation abandons the command silently and op_count clears.
- FSM states: IDLE, WAIT, RESP.
- cmd_ready = (state==IDLE), combinational from state only.
- Accept occurs on an edge T with cmd_valid && cmd_ready:
  - Latch tag and sel internally.
  - If cmd_sel==3 and cmd_b==0: do not touch alu_*. Load rsp_data=8'hFF, rsp_carry=0, rsp_err=1, rsp_tag, and go to RESP. rsp_valid is high from T.
  - Otherwise: register alu_a/alu_b/alu_sel from cmd_*, load wcnt=(cmd_sel==2 ? MUL_LAT : DEF_LAT), and go to WAIT.
- WAIT:
  - Each edge with wcnt!=0 decrements wcnt.
  - At the edge where wcnt==0: capture rsp_data=alu_out; rsp_carry=alu_carry if sel==0, else 0; rsp_err=0. Go to RESP.
  - The capture edge is therefore T+LAT+1. rsp_valid rises after T+2 for default ops and after T+3 for multiply.
  - wcnt is 2 bits wide and sized to cover max(DEF_LAT, MUL_LAT) <= 3.
- alu_a/alu_b/alu_sel hold their last issued value until the next non-trapped accept; they never return to 0 except on reset.
- RESP:
  - rsp_* stay stable while rsp_valid && !rsp_ready.
  - On an edge with rsp_ready: rsp_valid drops, op_count increments (wraps at 2^CNT_W-1 -> 0), and the FSM goes to IDLE.
  - No accept can occur on that same edge; the earliest next accept is the following edge, so peak throughput is one op per LAT+3 cycles.
- cmd_* are ignored while cmd_ready=0; cmd_valid may be held with no effect.
- rsp_ready asserted outside RESP has no effect.
- Trapped divides count in op_count.

Test Plan:
- Add with carry: rst 2 cycles, then cmd A=200 B=100 sel=0 tag=5, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_data=44, rsp_carry=1, rsp_err=0, rsp_tag=5, op_count=1.
- Multiply latency: A=7 B=6 sel=2 -> alu_sel=2 after accept edge; rsp_valid exactly 3 edges after accept; rsp_data=42, rsp_carry=0.
- Divide-by-zero: A=9 B=0 sel=3 tag=3 -> rsp_valid right after accept, rsp_data=FF, rsp_err=1; alu_sel still holds the previous opcode (2).
- Backpressure: rsp_ready=0 for 5 cycles on a sub A=10 B=3 -> rsp_data=7 held stable, cmd_ready=0 throughout; a second cmd held valid is accepted only on the edge after rsp_ready=1 handshake.
- Reset mid-WAIT: issue a multiply, assert rst one cycle later -> rsp_valid never rises, op_count=0, cmd_ready=1 next cycle, alu_* = 0.
- Sweep all 16 opcodes with A=0xA5 B=0x3C back-to-back -> 16 responses in order with golden ALU results; op_count=16; rsp_carry=0 for every opcode except 0.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU operand buses of the ALU op sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [3:0]        cmd_sel;
    logic [3:0]        cmd_tag;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
    logic              rsp_err;
    logic [3:0]        rsp_tag;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_carry,
        output rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_carry,
        input  rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Single-outstanding command sequencer in front of a registered 8-bit ALU:
// issues operands, waits the op latency, returns result with tag; traps divide-by-zero.
module alu_op_sequencer #(
    parameter int DATA_W  = 8,
    parameter int DEF_LAT = 1,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_op_sequencer_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] DEF_WAIT = 2'(DEF_LAT);
    localparam logic [1:0] MUL_WAIT = 2'(MUL_LAT);
    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_MUL  = 4'd2;
    localparam logic [3:0] SEL_DIV  = 4'd3;

    state_t     state;
    logic [1:0] wcnt;
    logic [3:0] sel_q;
    logic [3:0] tag_q;

    assign bus.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wcnt          <= '0;
            sel_q         <= '0;
            tag_q         <= '0;
            op_count      <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        sel_q <= bus.cmd_sel;
                        tag_q <= bus.cmd_tag;
                        // Divide by zero never reaches the ALU; the operand bus keeps the previous op.
                        if (bus.cmd_sel == SEL_DIV && bus.cmd_b == '0) begin
                            bus.rsp_data  <= '1;
                            bus.rsp_carry <= 1'b0;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_tag   <= bus.cmd_tag;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end else begin
                            bus.alu_a   <= bus.cmd_a;
                            bus.alu_b   <= bus.cmd_b;
                            bus.alu_sel <= bus.cmd_sel;
                            wcnt        <= (bus.cmd_sel == SEL_MUL) ? MUL_WAIT : DEF_WAIT;
                            state       <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (wcnt != 2'd0) begin
                        wcnt <= wcnt - 2'd1;
                    end else begin
                        bus.rsp_data  <= bus.alu_out;
                        bus.rsp_carry <= (sel_q == SEL_ADD) ? bus.alu_carry : 1'b0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_tag   <= tag_q;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + CNT_W'(1);
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
